// File: rtl/msk_share_encoder.sv
// msk_share_encoder
//   Masking front-end: turns an unmasked W-bit word into a d-share Boolean
//   sharing. Fresh share randomness comes from a seedable 32-bit LFSR; each
//   accepted word consumes exactly R = W*(d-1) LFSR steps that were produced
//   after the previous acceptance or reseed, so no random bit is ever reused.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   seed        : LFSR seed (zero is replaced by 1)
//   seed_valid  : load seed this cycle, always accepted
//   in_data     : unmasked word, valid/ready handshake with in_valid/in_ready
//   out         : sharing, share j of bit i at out[i*d+j]
//   out_valid   : out holds a sharing, held until out_ready
//   out_ready   : consumer takes out this cycle
module msk_share_encoder #(
  parameter int d = 2,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    seed,
  input  logic           seed_valid,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W*d-1:0] out,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int R  = W * (d - 1);
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

  typedef enum logic [1:0] {
    SEED  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     lfsr;
  logic [R-1:0]    rbuf;
  logic [CW-1:0]   cnt;
  logic            fb;
  logic [R-1:0]    rbuf_next;
  logic [W*d-1:0]  enc;
  logic            accept;

  assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];

  // Newest random bit always enters at rbuf[0].
  generate
    if (R == 1) begin : g_rbuf1
      assign rbuf_next = fb;
    end else begin : g_rbufn
      assign rbuf_next = {rbuf[R-2:0], fb};
    end
  endgenerate

  // A reseed on the same cycle blocks acceptance: the buffered randomness is
  // about to be discarded.
  assign in_ready = (state == READY) && (!out_valid || out_ready) && !seed_valid;
  assign accept   = in_valid && in_ready;

  // Shares 1..d-1 are raw random bits; share 0 closes the XOR to the data bit.
  always_comb begin
    logic x;
    enc = '0;
    x   = 1'b0;
    for (int i = 0; i < W; i++) begin
      x = in_data[i];
      for (int j = 1; j < d; j++) begin
        enc[i*d+j] = rbuf[i*(d-1)+j-1];
        x          = x ^ rbuf[i*(d-1)+j-1];
      end
      enc[i*d] = x;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      lfsr      <= '0;
      rbuf      <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      // Output stage: a same-edge accept overrides the consume (no bubble).
      if (accept) begin
        out       <= enc;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (seed_valid) begin
        // All-zero is the LFSR lock-up state, so it is never loaded.
        lfsr  <= (seed == 32'h0) ? 32'h1 : seed;
        rbuf  <= '0;
        cnt   <= '0;
        state <= FILL;
      end else begin
        case (state)
          FILL: begin
            lfsr <= {lfsr[30:0], fb};
            rbuf <= rbuf_next;
            cnt  <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= READY;
          end
          READY: begin
            if (accept) begin
              cnt   <= '0;
              state <= FILL;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msk_share_encoder.sv
module tb_msk_share_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: d=2, W=4 (directed + table tests)
  logic        rst2, sv2, iv2, ir2, ov2, or2;
  logic [31:0] seed2;
  logic [3:0]  in2;
  logic [7:0]  out2;

  // Large instance: d=3, W=8 (random stream)
  logic        rst3, sv3, iv3, ir3, ov3, or3;
  logic [31:0] seed3;
  logic [7:0]  in3;
  logic [23:0] out3;

  msk_share_encoder #(.d(2), .W(4)) u2 (
    .clk(clk), .rst(rst2), .seed(seed2), .seed_valid(sv2),
    .in_data(in2), .in_valid(iv2), .in_ready(ir2),
    .out(out2), .out_valid(ov2), .out_ready(or2));

  msk_share_encoder #(.d(3), .W(8)) u3 (
    .clk(clk), .rst(rst3), .seed(seed3), .seed_valid(sv3),
    .in_data(in3), .in_valid(iv3), .in_ready(ir3),
    .out(out3), .out_valid(ov3), .out_ready(or3));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Draw n fresh random bits from the LFSR; the most recent bit ends up at
  // index 0 of the returned buffer.
  function automatic logic [63:0] draw_bits(inout logic [31:0] s, input int n);
    logic [63:0] rb;
    logic        f;
    rb = '0;
    for (int k = 0; k < n; k++) begin
      f  = s[31] ^ s[21] ^ s[1] ^ s[0];
      s  = {s[30:0], f};
      rb = {rb[62:0], f};
    end
    return rb;
  endfunction

  function automatic logic [63:0] encode(input logic [31:0] data, input logic [63:0] rb,
                                         input int dd, input int ww);
    logic [63:0] o;
    logic        x;
    o = '0;
    for (int i = 0; i < ww; i++) begin
      x = data[i];
      for (int j = 1; j < dd; j++) begin
        o[i*dd+j] = rb[i*(dd-1)+j-1];
        x ^= rb[i*(dd-1)+j-1];
      end
      o[i*dd] = x;
    end
    return o;
  endfunction

  function automatic logic [31:0] recombine(input logic [63:0] o, input int dd, input int ww);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < ww; i++)
      for (int j = 0; j < dd; j++)
        r[i] = r[i] ^ o[i*dd+j];
    return r;
  endfunction

  // Expected d=2/W=4 word: the (skip+1)-th word encoded after seeding.
  function automatic logic [63:0] exp2(input logic [31:0] sd, input int skip, input logic [3:0] data);
    logic [31:0] s;
    logic [63:0] rb;
    s  = (sd == 32'h0) ? 32'h1 : sd;
    rb = '0;
    for (int k = 0; k <= skip; k++) rb = draw_bits(s, 4);
    return encode({28'h0, data}, rb, 2, 4);
  endfunction

  // ---------------- small-instance helpers ----------------
  // Convention: tasks start and end at posedge+1.
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic seed_u2(input logic [31:0] s);
    seed2 = s; sv2 = 1'b1;
    tick;
    sv2 = 1'b0;
  endtask

  // After a seed or accept edge: 4 FILL cycles with in_ready low, then high.
  task automatic chk_fill(input string name);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({name, " in_ready low in FILL"}, {63'h0, ir2}, 64'h0);
      tick;
    end
    @(negedge clk);
    chk({name, " in_ready after FILL"}, {63'h0, ir2}, 64'h1);
    tick;
  endtask

  task automatic accept_u2(input logic [3:0] data);
    in2 = data; iv2 = 1'b1;
    tick;
    iv2 = 1'b0;
  endtask

  typedef struct {
    logic [31:0] sd;
    logic [3:0]  data;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt[8];

  logic [63:0] q_exp[$];
  logic [31:0] q_dat[$];

  initial begin
    logic [31:0] ms;
    logic [63:0] e;
    logic [31:0] dd;
    int          acc_cnt;
    int          cyc;

    rst2 = 1'b1; sv2 = 1'b0; iv2 = 1'b0; or2 = 1'b1; seed2 = '0; in2 = '0;
    rst3 = 1'b1; sv3 = 1'b0; iv3 = 1'b0; or3 = 1'b0; seed3 = '0; in3 = '0;

    // Table: known-answer rows plus random seeds with model expectations.
    vt[0] = '{32'h1, 4'hA, 8'h8B};
    vt[1] = '{32'h0, 4'hA, 8'h8B};
    vt[2] = '{32'h1, 4'h0, 8'hCF};
    vt[3] = '{32'h1, 4'hF, 8'h9A};
    for (int k = 4; k < 8; k++) begin
      vt[k].sd   = $urandom;
      vt[k].data = 4'($urandom_range(0, 15));
      vt[k].exp  = exp2(vt[k].sd, 0, vt[k].data)[7:0];
    end

    // ---- reset state ----
    tick; tick;
    @(negedge clk);
    chk("reset out", {56'h0, out2}, 64'h0);
    chk("reset out_valid", {63'h0, ov2}, 64'h0);
    chk("reset in_ready", {63'h0, ir2}, 64'h0);
    rst2 = 1'b0;
    iv2 = 1'b1;
    tick;
    @(negedge clk);
    chk("SEED blocks input", {63'h0, ir2}, 64'h0);
    tick;
    iv2 = 1'b0;

    // ---- table-driven vectors ----
    for (int k = 0; k < 8; k++) begin
      or2 = 1'b1;
      seed_u2(vt[k].sd);
      chk_fill($sformatf("vec%0d seed", k));
      accept_u2(vt[k].data);
      chk($sformatf("vec%0d out", k), {56'h0, out2}, {56'h0, vt[k].exp});
      chk($sformatf("vec%0d out_valid", k), {63'h0, ov2}, 64'h1);
      chk($sformatf("vec%0d recombine", k), {32'h0, recombine({56'h0, out2}, 2, 4)}, {60'h0, vt[k].data});
      chk_fill($sformatf("vec%0d post-accept", k));
    end

    // ---- backpressure then same-edge consume+accept ----
    or2 = 1'b0;
    seed_u2(32'h1);
    chk_fill("bp seed");
    accept_u2(4'hA);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("bp out held", {56'h0, out2}, 64'h8B);
      chk("bp out_valid held", {63'h0, ov2}, 64'h1);
      if (k >= 4) chk("bp in_ready blocked", {63'h0, ir2}, 64'h0);
      tick;
    end
    @(negedge clk);
    or2 = 1'b1; in2 = 4'h5; iv2 = 1'b1;
    #1;
    chk("bp in_ready on release", {63'h0, ir2}, 64'h1);
    tick;
    iv2 = 1'b0; or2 = 1'b0;
    chk("pass-through out_valid", {63'h0, ov2}, 64'h1);
    chk("pass-through out", {56'h0, out2}, exp2(32'h1, 1, 4'h5));
    or2 = 1'b1;
    tick;
    @(negedge clk);
    chk("drain out_valid", {63'h0, ov2}, 64'h0);
    tick;

    // ---- reseed in FILL at cnt==2 ----
    seed_u2(32'h1);
    chk_fill("rs seed");
    accept_u2(4'hA);
    tick; tick;                 // two FILL steps done, cnt==2
    seed_u2(32'h1);
    chk_fill("rs restart");
    accept_u2(4'hA);
    chk("rs out", {56'h0, out2}, 64'h8B);

    // ---- mid-operation reset drops pending output ----
    or2 = 1'b0;
    rst2 = 1'b1;
    tick;
    rst2 = 1'b0;
    @(negedge clk);
    chk("mid reset out_valid", {63'h0, ov2}, 64'h0);
    chk("mid reset out", {56'h0, out2}, 64'h0);
    tick;

    // ---- random stream on d=3, W=8 ----
    rst3 = 1'b0;
    seed3 = $urandom | 32'h1;
    ms = seed3;
    sv3 = 1'b1;
    tick;
    sv3 = 1'b0;
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 1000 && cyc < 60000) begin
      @(negedge clk);
      if (ov3 && or3) begin
        if (q_exp.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL rand: output with no pending input, got %h", out3);
        end else begin
          e = q_exp.pop_front();
          dd = q_dat.pop_front();
          chk("rand out", {40'h0, out3}, e);
          chk("rand recombine", {32'h0, recombine({40'h0, out3}, 3, 8)}, {32'h0, dd});
        end
      end
      if (iv3 && ir3) begin
        q_exp.push_back(encode({24'h0, in3}, draw_bits(ms, 16), 3, 8));
        q_dat.push_back({24'h0, in3});
        acc_cnt++;
      end
      tick;
      cyc++;
      iv3 = ($urandom_range(0, 3) != 0);
      in3 = 8'($urandom);
      or3 = ($urandom_range(0, 3) != 0);
    end
    if (acc_cnt < 1000) begin
      nvec++; nerr++;
      $display("FAIL rand: only %0d of 1000 words accepted in cycle budget", acc_cnt);
    end
    iv3 = 1'b0; or3 = 1'b1;
    for (int k = 0; k < 50 && q_exp.size() > 0; k++) begin
      @(negedge clk);
      if (ov3) begin
        e = q_exp.pop_front();
        dd = q_dat.pop_front();
        chk("drain out", {40'h0, out3}, e);
        chk("drain recombine", {32'h0, recombine({40'h0, out3}, 3, 8)}, {32'h0, dd});
      end
      tick;
    end
    chk("rand nothing lost", 64'(q_exp.size()), 64'h0);
    @(negedge clk);
    chk("rand no duplicate", {63'h0, ov3}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
